// File: rtl/rs_tx_block_sched_pkg.sv
// Shared constants and types for the RS(N,K) TX block scheduler: link K-characters,
// fixed SOF/pad bytes, RS geometry defaults, FSM states and symbol-mux selects.
package rs_tx_block_sched_pkg;

  localparam int RS_CNT_W     = 10;
  localparam int RS_N_DEF     = 15;
  localparam int RS_K_DEF     = 11;
  localparam int MIN_IDLE_DEF = 4;

  localparam logic [7:0] CHAR_I   = 8'hBC;  // K28.5
  localparam logic [7:0] CHAR_S   = 8'hFB;  // K27.7
  localparam logic [7:0] CHAR_A   = 8'h7C;  // K28.3
  localparam logic [7:0] SOF_BYTE = 8'h55;
  localparam logic [7:0] PAD_BYTE = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOF  = 3'd1,
    ST_DATA = 3'd2,
    ST_PAD  = 3'd3,
    ST_CHK  = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    SEL_IDLE,
    SEL_SOF_S,
    SEL_SOF_A,
    SEL_SOF_D,
    SEL_PAYLOAD,
    SEL_PAD,
    SEL_PARITY
  } sym_sel_e;

endpackage

// File: rtl/rs_tx_sym_mux.sv
// Registered symbol mux feeding the 8b/10b encoder: picks idle, SOF, payload,
// pad or RS parity for the next transmitted symbol.
module rs_tx_sym_mux
  import rs_tx_block_sched_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  sym_sel_e   i_sel,
  input  logic [7:0] i_pl_data,
  input  logic [7:0] i_enc_chk,
  output logic [7:0] o_tx_data,
  output logic       o_tx_datak
);

  logic [7:0] tx_data_d, tx_data_q;
  logic       tx_datak_d, tx_datak_q;

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    tx_data_d  = CHAR_I;
    tx_datak_d = 1'b1;
    unique case (i_sel)
      SEL_SOF_S:   tx_data_d = CHAR_S;
      SEL_SOF_A:   tx_data_d = CHAR_A;
      SEL_SOF_D:   begin tx_data_d = SOF_BYTE;  tx_datak_d = 1'b0; end
      SEL_PAYLOAD: begin tx_data_d = i_pl_data; tx_datak_d = 1'b0; end
      SEL_PAD:     begin tx_data_d = PAD_BYTE;  tx_datak_d = 1'b0; end
      SEL_PARITY:  begin tx_data_d = i_enc_chk; tx_datak_d = 1'b0; end
      default:     ;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tx_data_q  <= CHAR_I;
      tx_datak_q <= 1'b1;
    end else begin
      tx_data_q  <= tx_data_d;
      tx_datak_q <= tx_datak_d;
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_datak = tx_datak_q;

endmodule

// File: rtl/rs_tx_block_sched.sv
// TX scheduler framing payload into RS(N,K) blocks: |I| gap, |S||A|55 SOF, data/pad, parity.
// Define RS_TX_SCHED_STATS_EN to add frame/block/underrun statistics counters.
module rs_tx_block_sched
  import rs_tx_block_sched_pkg::*;
#(
  parameter int RS_N     = RS_N_DEF,
  parameter int RS_K     = RS_K_DEF,
  parameter int MIN_IDLE = MIN_IDLE_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_link_up,
  input  logic        i_pl_vld,
  input  logic [7:0]  i_pl_data,
  input  logic        i_pl_last,
  output logic        o_pl_rdy,
  output logic        o_enc_sop,
  output logic        o_enc_vld,
  output logic [7:0]  o_enc_data,
  output logic        o_enc_chk_rd,
  input  logic [7:0]  i_enc_chk,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_datak,
  output logic        o_underrun
`ifdef RS_TX_SCHED_STATS_EN
  ,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_block_cnt,
  output logic [15:0] o_underrun_cnt
`endif
);

  localparam logic [RS_CNT_W-1:0] K_LAST   = RS_CNT_W'(RS_K - 1);
  localparam logic [RS_CNT_W-1:0] N_LAST   = RS_CNT_W'(RS_N - 1);
  localparam logic [RS_CNT_W-1:0] SOF_LAST = RS_CNT_W'(2);
  localparam int                  GAP_W    = $clog2(MIN_IDLE + 1);
  localparam logic [GAP_W-1:0]    GAP_MAX  = GAP_W'(MIN_IDLE);

  state_e              state_q, state_d;
  logic [RS_CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d, gap_inc;
  logic                done_q, done_d;
  sym_sel_e            sym_sel;
  logic                abort;

  assign abort   = !i_rst_n || !i_link_up;
  // gap_inc counts the |I| being emitted this cycle, so a held vld yields exactly MIN_IDLE idles.
  assign gap_inc = (gap_cnt_q == GAP_MAX) ? GAP_MAX : gap_cnt_q + GAP_W'(1);

  always_comb begin
    state_d      = state_q;
    blk_cnt_d    = blk_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    done_d       = done_q;
    sym_sel      = SEL_IDLE;
    o_pl_rdy     = 1'b0;
    o_enc_sop    = 1'b0;
    o_enc_vld    = 1'b0;
    o_enc_data   = 8'h00;
    o_enc_chk_rd = 1'b0;
    o_underrun   = 1'b0;
    if (abort) begin
      state_d   = ST_IDLE;
      blk_cnt_d = '0;
      gap_cnt_d = '0;
      done_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          gap_cnt_d = gap_inc;
          if (i_pl_vld && gap_inc == GAP_MAX) begin
            state_d   = ST_SOF;
            blk_cnt_d = '0;
            done_d    = 1'b0;
          end
        end
        ST_SOF: begin
          // SOF symbols occupy the first three data positions of block 0.
          o_enc_vld  = 1'b1;
          o_enc_data = SOF_BYTE;
          o_enc_sop  = (blk_cnt_q == '0);
          sym_sel    = (blk_cnt_q == '0)        ? SEL_SOF_S :
                       (blk_cnt_q == RS_CNT_W'(1)) ? SEL_SOF_A : SEL_SOF_D;
          blk_cnt_d  = blk_cnt_q + RS_CNT_W'(1);
          if (blk_cnt_q == SOF_LAST) state_d = ST_DATA;
        end
        ST_DATA: begin
          o_pl_rdy  = 1'b1;
          o_enc_vld = 1'b1;
          o_enc_sop = (blk_cnt_q == '0);
          blk_cnt_d = blk_cnt_q + RS_CNT_W'(1);
          if (i_pl_vld) begin
            sym_sel    = SEL_PAYLOAD;
            o_enc_data = i_pl_data;
            if (i_pl_last) done_d = 1'b1;
          end else begin
            sym_sel    = SEL_PAD;
            o_enc_data = PAD_BYTE;
            o_underrun = 1'b1;
          end
          if (blk_cnt_q == K_LAST)            state_d = ST_CHK;
          else if (i_pl_vld && i_pl_last)     state_d = ST_PAD;
        end
        ST_PAD: begin
          o_enc_vld  = 1'b1;
          o_enc_data = PAD_BYTE;
          sym_sel    = SEL_PAD;
          blk_cnt_d  = blk_cnt_q + RS_CNT_W'(1);
          if (blk_cnt_q == K_LAST) state_d = ST_CHK;
        end
        ST_CHK: begin
          o_enc_chk_rd = 1'b1;
          sym_sel      = SEL_PARITY;
          if (blk_cnt_q == N_LAST) begin
            blk_cnt_d = '0;
            if (done_q) begin
              state_d   = ST_IDLE;
              gap_cnt_d = '0;
              done_d    = 1'b0;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            blk_cnt_d = blk_cnt_q + RS_CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      blk_cnt_q <= '0;
      gap_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      blk_cnt_q <= blk_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      done_q    <= done_d;
    end
  end

  rs_tx_sym_mux u_sym_mux (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_sel      (sym_sel),
    .i_pl_data  (i_pl_data),
    .i_enc_chk  (i_enc_chk),
    .o_tx_data  (o_tx_data),
    .o_tx_datak (o_tx_datak)
  );

`ifdef RS_TX_SCHED_STATS_EN
  logic [15:0] frame_cnt_q, block_cnt_q, underrun_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      frame_cnt_q    <= '0;
      block_cnt_q    <= '0;
      underrun_cnt_q <= '0;
    end else begin
      if (state_q != ST_SOF && state_d == ST_SOF) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (state_q != ST_CHK && state_d == ST_CHK) block_cnt_q <= block_cnt_q + 16'd1;
      if (o_underrun) underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end
  end

  assign o_frame_cnt    = frame_cnt_q;
  assign o_block_cnt    = block_cnt_q;
  assign o_underrun_cnt = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_rs_tx_block_sched.sv
// Scoreboard bench for rs_tx_block_sched (RS_N=15, RS_K=11, MIN_IDLE=4): a frame-level
// model queues expected symbols; a monitor compares the tx and encoder streams.
module tb_rs_tx_block_sched;

  localparam int N        = 15;
  localparam int K        = 11;
  localparam int MIN_IDLE = 4;
  localparam logic [7:0] TB_I = 8'hBC;
  localparam logic [7:0] TB_S = 8'hFB;
  localparam logic [7:0] TB_A = 8'h7C;

  logic       clk = 1'b0;
  logic       rst_n, link_up, pl_vld, pl_last;
  logic [7:0] pl_data, enc_chk;
  logic       pl_rdy, enc_sop, enc_vld, enc_chk_rd, tx_datak, underrun;
  logic [7:0] enc_data, tx_data;
`ifdef RS_TX_SCHED_STATS_EN
  logic [15:0] frame_cnt, block_cnt, underrun_cnt;
`endif

  rs_tx_block_sched #(.RS_N(N), .RS_K(K), .MIN_IDLE(MIN_IDLE)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_link_up    (link_up),
    .i_pl_vld     (pl_vld),
    .i_pl_data    (pl_data),
    .i_pl_last    (pl_last),
    .o_pl_rdy     (pl_rdy),
    .o_enc_sop    (enc_sop),
    .o_enc_vld    (enc_vld),
    .o_enc_data   (enc_data),
    .o_enc_chk_rd (enc_chk_rd),
    .i_enc_chk    (enc_chk),
    .o_tx_data    (tx_data),
    .o_tx_datak   (tx_datak),
    .o_underrun   (underrun)
`ifdef RS_TX_SCHED_STATS_EN
    ,
    .o_frame_cnt    (frame_cnt),
    .o_block_cnt    (block_cnt),
    .o_underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       k;
    bit         parity;
    bit         sof;
    bit         eof;
  } tx_exp_t;

  typedef struct {
    logic [7:0] data;
    bit         sop;
    bit         underrun;
  } enc_exp_t;

  tx_exp_t    tx_q[$];
  enc_exp_t   enc_q[$];
  bit         gap_q[$];
  logic [7:0] frame_buf[$];
  int         frame_pos;
  bit         sb_en = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_tx(input logic [7:0] d, input logic k, input bit par,
                                  input bit sof, input bit eof);
    tx_exp_t e;
    e.data = d; e.k = k; e.parity = par; e.sof = sof; e.eof = eof;
    tx_q.push_back(e);
  endfunction

  function automatic void push_enc(input logic [7:0] d, input bit sop, input bit ur);
    enc_exp_t e;
    e.data = d; e.sop = sop; e.underrun = ur;
    enc_q.push_back(e);
  endfunction

  // One data position of the frame; completes pad and parity when the block fills or the frame ends.
  function automatic void push_item(input logic [7:0] d, input bit ur, input bit last);
    push_tx(d, 1'b0, 1'b0, 1'b0, 1'b0);
    push_enc(d, (frame_pos % K) == 0, ur);
    frame_pos++;
    if (last) begin
      while ((frame_pos % K) != 0) begin
        push_tx(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        push_enc(8'h00, 1'b0, 1'b0);
        frame_pos++;
      end
    end
    if ((frame_pos % K) == 0) begin
      for (int i = 0; i < N - K; i++) push_tx(8'h00, 1'b0, 1'b1, 1'b0, last && (i == N - K - 1));
    end
  endfunction

  // Called right after a negedge; returns right after the negedge following the last acceptance.
  task automatic run_frame(input int wait_cyc, input bit exact, input int stall_pct, input int stall_idx);
    int idx, budget, stalls_left;
    bit stalled;
    idx = 0; budget = 0; stalls_left = 0; stalled = 1'b0;
    if (wait_cyc > 0) begin
      pl_vld = 1'b0;
      repeat (wait_cyc) @(negedge clk);
    end
    push_tx(TB_S, 1'b1, 1'b0, 1'b1, 1'b0);
    push_tx(TB_A, 1'b1, 1'b0, 1'b0, 1'b0);
    push_tx(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    push_enc(8'h55, 1'b1, 1'b0);
    push_enc(8'h55, 1'b0, 1'b0);
    push_enc(8'h55, 1'b0, 1'b0);
    gap_q.push_back(exact);
    frame_pos = 3;
    while (idx < frame_buf.size() && budget < 3000) begin
      if (pl_rdy && idx == stall_idx && !stalled) begin
        stalls_left = 2;
        stalled = 1'b1;
      end
      if (pl_rdy && (stalls_left > 0 || $urandom_range(0, 99) < stall_pct)) begin
        pl_vld  = 1'b0;
        pl_data = 8'($urandom);
        pl_last = 1'($urandom);
        push_item(8'h00, 1'b1, 1'b0);
        if (stalls_left > 0) stalls_left--;
      end else begin
        pl_vld  = 1'b1;
        pl_data = frame_buf[idx];
        pl_last = (idx == frame_buf.size() - 1);
        if (pl_rdy) begin
          push_item(frame_buf[idx], 1'b0, pl_last);
          idx++;
        end
      end
      @(negedge clk);
      budget++;
    end
    check("frame_bytes_accepted", idx, frame_buf.size());
  endtask

  initial begin
    enc_chk = 8'h00;
    forever begin
      @(negedge clk);
      enc_chk = 8'($urandom);
    end
  end

  // Monitor: tx symbols lag the decision by one cycle, encoder outputs are same-cycle.
  initial begin
    bit         prev_chk_rd, in_frame;
    logic [7:0] chk_prev, exp_d;
    int         idle_run;
    tx_exp_t    et;
    enc_exp_t   ee;
    prev_chk_rd = 1'b0; in_frame = 1'b0; chk_prev = 8'h00; idle_run = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!sb_en) begin
        idle_run = 0;
        in_frame = 1'b0;
      end else begin
        if (tx_datak && tx_data == TB_I) begin
          check("idle_inside_block", in_frame, 0);
          check("chk_rd_before_idle", prev_chk_rd, 0);
          idle_run++;
        end else begin
          check("tx_symbol_expected", tx_q.size() != 0, 1);
          if (tx_q.size() != 0) begin
            et = tx_q.pop_front();
            exp_d = et.parity ? chk_prev : et.data;
            check("tx_data", tx_data, exp_d);
            check("tx_datak", tx_datak, et.k);
            check("chk_rd_align", prev_chk_rd, et.parity);
            if (et.sof) begin
              check("idle_gap_min", idle_run >= MIN_IDLE, 1);
              if (gap_q.size() != 0) begin
                if (gap_q.pop_front()) check("idle_gap_exact", idle_run, MIN_IDLE);
              end
              in_frame = 1'b1;
            end
            if (et.eof) in_frame = 1'b0;
          end
          idle_run = 0;
        end
        if (enc_vld) begin
          check("enc_symbol_expected", enc_q.size() != 0, 1);
          if (enc_q.size() != 0) begin
            ee = enc_q.pop_front();
            check("enc_data", enc_data, ee.data);
            check("enc_sop", enc_sop, ee.sop);
            check("underrun", underrun, ee.underrun);
          end
        end else begin
          check("enc_flags_when_idle", {enc_sop, underrun}, 2'b00);
        end
      end
      prev_chk_rd = enc_chk_rd;
      chk_prev    = enc_chk;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt, wait_cyc;
    bit  found, accepted;
    rst_n = 1'b0; link_up = 1'b1; pl_vld = 1'b0; pl_last = 1'b0; pl_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx_data", tx_data, TB_I);
    check("rst_tx_datak", tx_datak, 1);
    check("rst_outputs", {pl_rdy, enc_sop, enc_vld, enc_chk_rd, underrun}, 5'b0);
    check("rst_enc_data", enc_data, 8'h00);
    rst_n  = 1'b1;
    sb_en  = 1'b1;

    // 8-byte frame fills block 0 exactly; 10-byte frame spills into a padded block 1.
    frame_buf.delete();
    for (int i = 1; i <= 8; i++) frame_buf.push_back(8'(i));
    run_frame(0, 1'b0, 0, -1);
    frame_buf.delete();
    for (int i = 1; i <= 10; i++) frame_buf.push_back(8'(i));
    run_frame(0, 1'b1, 0, -1);
    frame_buf.delete();
    for (int i = 1; i <= 20; i++) frame_buf.push_back(8'(8'h20 + i));
    run_frame(0, 1'b1, 0, 4);

    for (int f = 0; f < 25; f++) begin
      frame_buf.delete();
      cnt = $urandom_range(1, 35);
      for (int i = 0; i < cnt; i++) frame_buf.push_back(8'($urandom));
      wait_cyc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0;
      run_frame(wait_cyc, wait_cyc == 0, $urandom_range(0, 25), -1);
    end

    pl_vld = 1'b0;
    pl_last = 1'b0;
    cnt = 0;
    while ((tx_q.size() != 0 || enc_q.size() != 0) && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    check("scoreboard_drained", tx_q.size() + enc_q.size(), 0);
    repeat (3) @(negedge clk);
    sb_en = 1'b0;

    // Link drop on the second SOF symbol aborts the frame.
    pl_vld = 1'b1; pl_data = 8'hA5; pl_last = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (tx_datak && tx_data == TB_S) found = 1'b1;
    end
    check("sof_seen_before_linkdown", found, 1);
    link_up = 1'b0;
    #1;
    check("linkdown_rdy", pl_rdy, 0);
    check("linkdown_enc_vld", enc_vld, 0);
    @(negedge clk);
    check("linkdown_tx_data", tx_data, TB_I);
    check("linkdown_tx_datak", tx_datak, 1);
    link_up = 1'b1;
    cnt = 1; found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (tx_datak && tx_data == TB_S) found = 1'b1;
      else if (tx_datak && tx_data == TB_I) cnt++;
    end
    check("restart_sof_seen", found, 1);
    check("restart_idle_gap", cnt >= MIN_IDLE, 1);

    // Single-edge reset while parity is being read.
    found = 1'b0; accepted = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (accepted) pl_vld = 1'b0;
      if (pl_rdy) accepted = 1'b1;
      if (enc_chk_rd) found = 1'b1;
    end
    check("chk_reached", found, 1);
    pl_vld = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    check("chk_reset_tx_data", tx_data, TB_I);
    check("chk_reset_tx_datak", tx_datak, 1);
    check("chk_reset_chk_rd", enc_chk_rd, 0);
    check("chk_reset_rdy", pl_rdy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_reset_idle", {tx_datak, tx_data}, {1'b1, TB_I});
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
